// File: rtl/swipt_freq_tracker.sv
// Hill-climbing resonance tracker for the SWIPT transmitter: settle, average, climb with
// step halving on reversal, clamp to the band, lock, and re-acquire when power drops.
module swipt_freq_tracker #(
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned FREQ_W     = 20,
  parameter int unsigned FREQ_INIT  = 40000,
  parameter int unsigned FREQ_MIN   = 20000,
  parameter int unsigned FREQ_MAX   = 80000,
  parameter int unsigned STEP_INIT  = 100,
  parameter int unsigned STEP_MIN   = 6,
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned DROP_THR   = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              adc_valid,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_upd,
  output logic              freq_opt,
  output logic [ADC_W-1:0]  peak_level,
  output logic              busy
);

  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [SET_W-1:0]    SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [AVG_LOG2-1:0] SMP_LAST = '1;
  localparam logic [FREQ_W-1:0]   F_INIT   = FREQ_W'(FREQ_INIT);
  localparam logic [FREQ_W:0]     F_MIN_X  = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0]     F_MAX_X  = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W-1:0]   S_INIT   = FREQ_W'(STEP_INIT);
  localparam logic [FREQ_W-1:0]   S_MIN    = FREQ_W'(STEP_MIN);
  localparam logic [ADC_W:0]      DROP_X   = (ADC_W+1)'(DROP_THR);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [FREQ_W-1:0]   freq_q, freq_d, best_q, best_d, step_q, step_d;
  logic                dir_up_q, dir_up_d, first_q, first_d, upd_q, upd_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AVG_LOG2-1:0] smp_q, smp_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [ADC_W-1:0]    peak_q, peak_d;

  logic [ADC_W-1:0]  avg, avg_now;
  logic [ACC_W-1:0]  sum_now;
  logic              better, dir_a, dir_b, at_bound, drop;
  logic [FREQ_W-1:0] best_n, step_a, step_b, next_f;
  logic [FREQ_W:0]   raw_a;

  // Unclamped neighbour in FREQ_W+1 bits; downward moves saturate at zero.
  function automatic logic [FREQ_W:0] raw_step(input logic [FREQ_W-1:0] base,
                                               input logic [FREQ_W-1:0] step,
                                               input logic              up);
    if (up) return {1'b0, base} + {1'b0, step};
    if (step > base) return '0;
    return {1'b0, base} - {1'b0, step};
  endfunction

  function automatic logic out_of_band(input logic [FREQ_W:0] f);
    return (f < F_MIN_X) || (f > F_MAX_X);
  endfunction

  function automatic logic [FREQ_W-1:0] clamp(input logic [FREQ_W:0] f);
    if (f < F_MIN_X) return F_MIN_X[FREQ_W-1:0];
    if (f > F_MAX_X) return F_MAX_X[FREQ_W-1:0];
    return f[FREQ_W-1:0];
  endfunction

  // Decision datapath: every move is taken from best_n, which equals freq on an improvement.
  always_comb begin
    avg      = ADC_W'(acc_q >> AVG_LOG2);
    better   = first_q || (avg >= peak_q);
    best_n   = better ? freq_q : best_q;
    step_a   = better ? step_q : (step_q >> 1);
    dir_a    = better ? dir_up_q : ~dir_up_q;
    raw_a    = raw_step(best_n, step_a, dir_a);
    at_bound = out_of_band(raw_a) && (clamp(raw_a) == freq_q);
    step_b   = at_bound ? (step_a >> 1) : step_a;
    dir_b    = at_bound ? ~dir_a : dir_a;
    next_f   = clamp(raw_step(best_n, step_b, dir_b));
    sum_now  = acc_q + ACC_W'(adc_in);
    avg_now  = ADC_W'(sum_now >> AVG_LOG2);
    drop     = ({1'b0, avg_now} + DROP_X) < {1'b0, peak_q};
  end

  // NOTE: every variable gets its hold value first, so no branch can infer a latch.
  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    best_d   = best_q;
    step_d   = step_q;
    dir_up_d = dir_up_q;
    first_d  = first_q;
    acc_d    = acc_q;
    smp_d    = smp_q;
    set_d    = set_q;
    peak_d   = peak_q;
    upd_d    = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      acc_d   = '0;
      smp_d   = '0;
      set_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          freq_d   = F_INIT;
          step_d   = S_INIT;
          dir_up_d = 1'b1;
          first_d  = 1'b1;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          set_d = set_q + SET_W'(1);
          if (set_q == SET_LAST) begin
            set_d   = '0;
            acc_d   = '0;
            smp_d   = '0;
            state_d = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (adc_valid) begin
            acc_d = sum_now;
            smp_d = smp_q + AVG_LOG2'(1);
            if (smp_q == SMP_LAST) state_d = S_DECIDE;
          end
        end
        S_DECIDE: begin
          acc_d    = '0;
          smp_d    = '0;
          best_d   = best_n;
          step_d   = step_b;
          dir_up_d = dir_b;
          if (better) begin
            peak_d  = avg;
            first_d = 1'b0;
          end
          if (step_b < S_MIN) begin
            freq_d  = best_n;
            upd_d   = (best_n != freq_q);
            state_d = S_LOCKED;
          end else begin
            freq_d  = next_f;
            upd_d   = (next_f != freq_q);
            state_d = S_SETTLE;
          end
        end
        S_LOCKED: begin
          if (adc_valid) begin
            acc_d = sum_now;
            smp_d = smp_q + AVG_LOG2'(1);
            if (smp_q == SMP_LAST) begin
              acc_d = '0;
              smp_d = '0;
              if (drop) begin
                step_d   = S_INIT;
                dir_up_d = 1'b1;
                first_d  = 1'b1;
                state_d  = S_SETTLE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q  <= S_IDLE;
      freq_q   <= F_INIT;
      best_q   <= F_INIT;
      step_q   <= S_INIT;
      dir_up_q <= 1'b1;
      first_q  <= 1'b1;
      acc_q    <= '0;
      smp_q    <= '0;
      set_q    <= '0;
      peak_q   <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      best_q   <= best_d;
      step_q   <= step_d;
      dir_up_q <= dir_up_d;
      first_q  <= first_d;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      set_q    <= set_d;
      peak_q   <= peak_d;
      upd_q    <= upd_d;
    end
  end

  assign freq       = freq_q;
  assign freq_upd   = upd_q;
  assign peak_level = peak_q;
  assign freq_opt   = (state_q == S_LOCKED);
  assign busy       = (state_q == S_SETTLE) || (state_q == S_MEASURE) || (state_q == S_DECIDE);

endmodule

// File: tb/tb_swipt_freq_tracker.sv
// Directed bench for swipt_freq_tracker: a resonance-peak power model feeds adc_in from freq,
// and lock frequencies, peaks and update timing are checked against hand-traced values.
module tb_swipt_freq_tracker;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic [11:0] adc_in;
  logic        adc_valid;
  logic [19:0] freq;
  logic        freq_upd;
  logic        freq_opt;
  logic [11:0] peak_level;
  logic        busy;

  swipt_freq_tracker #(.SETTLE_CYC(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .adc_in     (adc_in),
    .adc_valid  (adc_valid),
    .freq       (freq),
    .freq_upd   (freq_upd),
    .freq_opt   (freq_opt),
    .peak_level (peak_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Power model: 3000 at the peak, falling 1 LSB per 8 Hz of detuning, floored at zero.
  int peak_f = 43000;
  int vdiv   = 1;
  int vph    = 0;

  function automatic logic [11:0] model(input int f, input int pk);
    int d;
    int v;
    d = (f > pk) ? f - pk : pk - f;
    v = 3000 - d / 8;
    return (v < 0) ? 12'd0 : 12'(v);
  endfunction

  always @(negedge clk) begin
    adc_in    = model(int'(freq), peak_f);
    vph       = (vph + 1) % vdiv;
    adc_valid = (vph == 0);
  end

  // Background watch: freq_upd must coincide exactly with freq changes and freq stays in band.
  bit          mon_on = 1'b0;
  logic [19:0] prev_f = '0;
  int          upd_err = 0;
  int          band_err = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if ((freq != prev_f) != freq_upd) upd_err++;
      if (freq < 20000 || freq > 80000) band_err++;
    end
    prev_f = freq;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_upd(input string tag, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!freq_upd && cyc < budget);
    check({tag, "_upd_seen"}, freq_upd, 1);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int n;
    n = 0;
    while (!freq_opt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_locked"}, freq_opt, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_freq"}, freq, 40000);
    check({tag, "_peak"}, peak_level, 0);
    check({tag, "_upd"}, freq_upd, 0);
    check({tag, "_opt"}, freq_opt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset();
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int n;
    nrst      = 1'b1;
    enable    = 1'b1;
    adc_in    = '0;
    adc_valid = 1'b0;

    // Reset held with enable high: reset wins and the block stays idle.
    tick(2);
    check_reset_outs("rst");
    nrst = 1'b0;
    tick(1);
    check("start_busy", busy, 1);
    check("start_no_upd", freq_upd, 0);
    check("start_freq", freq, 40000);
    mon_on = 1'b1;

    // Scenario 1: peak at 43000, valid every cycle.
    wait_upd("s1a", 100, cyc);
    check("s1_first_interval", cyc, 33);
    check("s1_first_freq", freq, 40100);
    check("s1_first_peak", peak_level, 2625);
    wait_upd("s1b", 100, cyc);
    check("s1_second_interval", cyc, 33);
    check("s1_second_freq", freq, 40200);
    wait_lock("s1", 3000);
    check("s1_lock_freq", freq, 43006);
    check("s1_lock_peak", peak_level, 3000);
    check("s1_lock_busy", busy, 0);

    // Scenario 3: peak moves to 43806, locked level drops by 100.
    peak_f = 43806;
    n = 0;
    while (freq_opt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("s3_opt_fell", freq_opt, 0);
    check("s3_busy", busy, 1);
    check("s3_freq_held", freq, 43006);
    wait_upd("s3a", 100, cyc);
    check("s3_restart_freq", freq, 43106);
    check("s3_restart_peak", peak_level, 2900);
    wait_lock("s3", 2000);
    check("s3_lock_freq", freq, 43812);
    check("s3_lock_peak", peak_level, 3000);
    check("s13_upd_coincident", upd_err, 0);
    mon_on = 1'b0;

    // Scenario 6b: reset while locked.
    pulse_reset();
    check_reset_outs("rst_locked");
    nrst = 1'b0;

    // Scenario 2: peak beyond the band.
    peak_f = 85000;
    tick(1);
    upd_err  = 0;
    band_err = 0;
    mon_on   = 1'b1;
    wait_lock("s2", 16000);
    check("s2_lock_freq", freq, 80000);
    check("s2_lock_peak", peak_level, 2375);
    check("s2_band", band_err, 0);
    check("s2_upd_coincident", upd_err, 0);
    mon_on = 1'b0;

    // Scenario 4: adc_valid one cycle in three.
    pulse_reset();
    nrst   = 1'b0;
    peak_f = 43000;
    vdiv   = 3;
    tick(1);
    wait_upd("s4a", 200, cyc);
    check("s4_interval_range", (cyc >= 63 && cyc <= 65), 1);
    check("s4_first_freq", freq, 40100);
    wait_lock("s4", 8000);
    check("s4_lock_freq", freq, 43006);
    check("s4_lock_peak", peak_level, 3000);
    vdiv = 1;

    // Scenario 5: enable dropped mid-measurement, then restored.
    pulse_reset();
    nrst = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) wait_upd("s5pre", 100, cyc);
    check("s5_pre_freq", freq, 40300);
    tick(21);
    check("s5_mid_busy", busy, 1);
    enable = 1'b0;
    tick(1);
    check("s5_idle_busy", busy, 0);
    check("s5_idle_freq", freq, 40300);
    check("s5_idle_opt", freq_opt, 0);
    check("s5_idle_upd", freq_upd, 0);
    check("s5_idle_peak", peak_level, 2650);
    tick(5);
    check("s5_hold_freq", freq, 40300);
    enable = 1'b1;
    tick(1);
    check("s5_reen_freq", freq, 40000);
    check("s5_reen_busy", busy, 1);
    check("s5_reen_upd", freq_upd, 0);
    wait_upd("s5a", 100, cyc);
    check("s5_first_interval", cyc, 33);
    check("s5_first_path_freq", freq, 40100);
    check("s5_first_path_peak", peak_level, 2625);

    // Scenario 6a: reset mid-settle.
    tick(5);
    check("s6_settle_busy", busy, 1);
    pulse_reset();
    check_reset_outs("rst_settle");
    nrst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
